// File: rtl/stage_sequencer_pkg.sv
// Shared constants for the multicycle stage sequencer: MIPS32 opcode/funct
// values, FSM states and the latched stage footprint.
package stage_sequencer_pkg;

    localparam int unsigned OP_WIDTH = 6;

    localparam logic [OP_WIDTH-1:0] R_TYPE    = 6'h00;
    localparam logic [OP_WIDTH-1:0] BGEZ_BLTZ = 6'h01;
    localparam logic [OP_WIDTH-1:0] J         = 6'h02;
    localparam logic [OP_WIDTH-1:0] JAL       = 6'h03;
    localparam logic [OP_WIDTH-1:0] BEQ       = 6'h04;
    localparam logic [OP_WIDTH-1:0] BNE       = 6'h05;
    localparam logic [OP_WIDTH-1:0] BLEZ      = 6'h06;
    localparam logic [OP_WIDTH-1:0] BGTZ      = 6'h07;
    localparam logic [OP_WIDTH-1:0] ADDI      = 6'h08;
    localparam logic [OP_WIDTH-1:0] ADDIU     = 6'h09;
    localparam logic [OP_WIDTH-1:0] SLTI      = 6'h0A;
    localparam logic [OP_WIDTH-1:0] SLTIU     = 6'h0B;
    localparam logic [OP_WIDTH-1:0] ANDI      = 6'h0C;
    localparam logic [OP_WIDTH-1:0] ORI       = 6'h0D;
    localparam logic [OP_WIDTH-1:0] XORI      = 6'h0E;
    localparam logic [OP_WIDTH-1:0] LUI       = 6'h0F;
    localparam logic [OP_WIDTH-1:0] LB        = 6'h20;
    localparam logic [OP_WIDTH-1:0] LH        = 6'h21;
    localparam logic [OP_WIDTH-1:0] LW        = 6'h23;
    localparam logic [OP_WIDTH-1:0] LBU       = 6'h24;
    localparam logic [OP_WIDTH-1:0] LHU       = 6'h25;
    localparam logic [OP_WIDTH-1:0] SB        = 6'h28;
    localparam logic [OP_WIDTH-1:0] SH        = 6'h29;
    localparam logic [OP_WIDTH-1:0] SW        = 6'h2B;

    localparam logic [5:0] JR = 6'h08;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    // Field order fixes the footprint bit positions: ex=3, mem=2, wb=1, illegal=0.
    typedef struct packed {
        logic ex;
        logic mem;
        logic wb;
        logic illegal;
    } footprint_t;

    function automatic state_e after_stage(footprint_t fp, state_e cur);
        state_e nxt;
        nxt = S_IF;
        case (cur)
            S_ID:    nxt = fp.ex ? S_EX : (fp.mem ? S_MEM : (fp.wb ? S_WB : S_IF));
            S_EX:    nxt = fp.mem ? S_MEM : (fp.wb ? S_WB : S_IF);
            S_MEM:   nxt = fp.wb ? S_WB : S_IF;
            default: nxt = S_IF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/stage_sequencer_footprint_decode.sv
// Combinational opcode/funct to stage footprint decode; unknown opcodes map
// to an empty footprint flagged illegal.
module footprint_decode
    import stage_sequencer_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op_code_i,
    input  logic [5:0]          funct_i,
    output footprint_t          fp_o
);

    always_comb begin
        fp_o = '0;
        case (op_code_i)
            R_TYPE: begin
                fp_o.ex = 1'b1;
                fp_o.wb = (funct_i != JR);
            end
            ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, JAL: begin
                fp_o.ex = 1'b1;
                fp_o.wb = 1'b1;
            end
            LB, LBU, LH, LHU, LW: begin
                fp_o.ex  = 1'b1;
                fp_o.mem = 1'b1;
                fp_o.wb  = 1'b1;
            end
            SB, SH, SW: begin
                fp_o.ex  = 1'b1;
                fp_o.mem = 1'b1;
            end
            BEQ, BNE, BLEZ, BGTZ, BGEZ_BLTZ, J: begin
                fp_o.ex = 1'b1;
            end
            default: fp_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle IF/ID/EX/MEM/WB control sequencer with one commit strobe per
// executed stage and a retired-instruction counter.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] op_code,
    input  logic [5:0]          funct,
    input  logic                mem_ready,
    input  logic                halt,
    output logic                if_en,
    output logic                id_en,
    output logic                ex_en,
    output logic                mem_en,
    output logic                wb_en,
    output logic                mem_req,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    state_e           state_q, state_d;
    footprint_t       fp_q, fp_d, fp_dec;
    logic [CNT_W-1:0] retired_q, retired_d;

    footprint_decode u_decode (
        .op_code_i (op_code),
        .funct_i   (funct),
        .fp_o      (fp_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            fp_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            fp_q      <= fp_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fp_d       = fp_q;
        if_en      = 1'b0;
        id_en      = 1'b0;
        ex_en      = 1'b0;
        mem_en     = 1'b0;
        wb_en      = 1'b0;
        mem_req    = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            S_IF: begin
                if (halt) begin
                    state_d = S_HALT;
                end else begin
                    // IF outputs are gated by rst so they drop while reset is held.
                    mem_req = rst;
                    if (mem_ready) begin
                        if_en   = rst;
                        fp_d    = fp_dec;
                        state_d = S_ID;
                    end
                end
            end
            S_ID: begin
                id_en      = 1'b1;
                illegal_op = fp_q.illegal;
                state_d    = after_stage(fp_q, S_ID);
                instr_done = (state_d == S_IF);
            end
            S_EX: begin
                ex_en      = 1'b1;
                state_d    = after_stage(fp_q, S_EX);
                instr_done = (state_d == S_IF);
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    mem_en     = 1'b1;
                    state_d    = after_stage(fp_q, S_MEM);
                    instr_done = (state_d == S_IF);
                end
            end
            S_WB: begin
                wb_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt) state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
        retired_d = retired_q + CNT_W'(instr_done);
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: vector table, hand-written corner
// sequences and randomized instructions against a per-stage trace model.
`timescale 1ns/1ps
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op_code = '0;
    logic [5:0]  funct = '0;
    logic        mem_ready = 1'b0;
    logic        halt = 1'b0;

    logic        if_en, id_en, ex_en, mem_en, wb_en, mem_req, instr_done, illegal_op, halted;
    logic [31:0] retired;
    logic        if_en_w, id_en_w, ex_en_w, mem_en_w, wb_en_w, mem_req_w, instr_done_w, illegal_op_w, halted_w;
    logic [3:0]  retired_w;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    logic [31:0] ret_model = '0;

    always #5 clk = ~clk;

    stage_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct),
        .mem_ready(mem_ready), .halt(halt),
        .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .mem_req(mem_req), .instr_done(instr_done), .illegal_op(illegal_op),
        .halted(halted), .retired(retired)
    );

    // Narrow counter instance exercises the modulo-2^CNT_W wrap.
    stage_sequencer #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct),
        .mem_ready(mem_ready), .halt(halt),
        .if_en(if_en_w), .id_en(id_en_w), .ex_en(ex_en_w), .mem_en(mem_en_w), .wb_en(wb_en_w),
        .mem_req(mem_req_w), .instr_done(instr_done_w), .illegal_op(illegal_op_w),
        .halted(halted_w), .retired(retired_w)
    );

    // Observed/expected vector: {if,id,ex,mem,wb,mem_req,instr_done,illegal_op,halted}
    typedef struct {
        logic       mr;
        logic [8:0] exp;
    } cyc_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        int unsigned cycles;
    } vec_t;

    cyc_t trace[$];

    function automatic logic [8:0] obs();
        return {if_en, id_en, ex_en, mem_en, wb_en, mem_req, instr_done, illegal_op, halted};
    endfunction

    function automatic logic [8:0] obs_w();
        return {if_en_w, id_en_w, ex_en_w, mem_en_w, wb_en_w, mem_req_w, instr_done_w, illegal_op_w, halted_w};
    endfunction

    // stage: 0 none, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
    function automatic logic [8:0] mk(int unsigned stage, logic req, logic done, logic ill, logic hlt);
        logic [4:0] s;
        s = (stage == 0) ? 5'b00000 : (5'b10000 >> (stage - 1));
        return {s, req, done, ill, hlt};
    endfunction

    // Returns {ex,mem,wb,illegal} straight from the instruction-class table.
    function automatic logic [3:0] ref_fp(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h00:                                                 return (fn == 6'h08) ? 4'b1000 : 4'b1010;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h03: return 4'b1010;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:                     return 4'b1110;
            6'h28, 6'h29, 6'h2B:                                   return 4'b1100;
            6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02:              return 4'b1000;
            default:                                               return 4'b0001;
        endcase
    endfunction

    function automatic void build(logic [5:0] op, logic [5:0] fn, int unsigned if_wait, int unsigned mem_wait);
        logic [3:0]  f;
        int unsigned stages[$];
        logic        last;
        f = ref_fp(op, fn);
        trace.delete();
        stages.push_back(1);
        stages.push_back(2);
        if (f[3]) stages.push_back(3);
        if (f[2]) stages.push_back(4);
        if (f[1]) stages.push_back(5);
        foreach (stages[i]) begin
            last = (i == stages.size() - 1);
            case (stages[i])
                1: begin
                    repeat (if_wait) trace.push_back('{1'b0, mk(0, 1'b1, 1'b0, 1'b0, 1'b0)});
                    trace.push_back('{1'b1, mk(1, 1'b1, 1'b0, 1'b0, 1'b0)});
                end
                2: trace.push_back('{1'($urandom), mk(2, 1'b0, last, f[0], 1'b0)});
                3: trace.push_back('{1'($urandom), mk(3, 1'b0, last, 1'b0, 1'b0)});
                4: begin
                    repeat (mem_wait) trace.push_back('{1'b0, mk(0, 1'b1, 1'b0, 1'b0, 1'b0)});
                    trace.push_back('{1'b1, mk(4, 1'b1, last, 1'b0, 1'b0)});
                end
                default: trace.push_back('{1'($urandom), mk(5, 1'b0, 1'b1, 1'b0, 1'b0)});
            endcase
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Entered and left at a falling edge with the DUT expected in IF.
    task automatic exec(input logic [5:0] op, input logic [5:0] fn,
                        input int unsigned if_wait, input int unsigned mem_wait,
                        input bit halt_in_ex,
                        output int unsigned dut_cycles, output int unsigned req_after_id);
        bit past_id;
        build(op, fn, if_wait, mem_wait);
        op_code = op;
        funct = fn;
        dut_cycles = 0;
        req_after_id = 0;
        past_id = 0;
        foreach (trace[i]) begin
            mem_ready = trace[i].mr;
            if (halt_in_ex && trace[i].exp[6]) halt = 1'b1;
            #1;
            check("strobes", 32'(obs()), 32'(trace[i].exp));
            check("strobes_w", 32'(obs_w()), 32'(trace[i].exp));
            if (instr_done && dut_cycles == 0) dut_cycles = i + 1;
            if (past_id && mem_req) req_after_id++;
            if (id_en) past_id = 1;
            @(negedge clk);
        end
        ret_model = ret_model + 1;
        check("retired", retired, ret_model);
        check("retired_wrap", 32'(retired_w), 32'(ret_model[3:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[$];
        logic [5:0]  known[$];
        int unsigned cyc, mrq;
        logic [5:0]  op, fn;

        vecs = '{
            '{6'h08, 6'h00, 4}, '{6'h23, 6'h00, 5}, '{6'h2B, 6'h00, 4}, '{6'h04, 6'h00, 3},
            '{6'h00, 6'h08, 3}, '{6'h00, 6'h20, 4}, '{6'h3F, 6'h00, 2}, '{6'h03, 6'h00, 4},
            '{6'h0F, 6'h00, 4}, '{6'h01, 6'h00, 3}, '{6'h02, 6'h00, 3}, '{6'h24, 6'h11, 5},
            '{6'h29, 6'h00, 4}, '{6'h10, 6'h00, 2}
        };
        known = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                  6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24,
                  6'h25, 6'h28, 6'h29, 6'h2B};

        // Reset state, with mem_ready high to show IF outputs stay low in reset.
        mem_ready = 1'b1;
        op_code = 6'h08;
        #1;
        check("reset_outputs", 32'(obs()), 32'd0);
        check("reset_retired", retired, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            exec(vecs[i].op, vecs[i].fn, 0, 0, 0, cyc, mrq);
            check($sformatf("cpi_op%02h", vecs[i].op), cyc, vecs[i].cycles);
        end

        // LW with two MEM wait cycles: 7 cycles, mem_req held 3 cycles in MEM.
        exec(6'h23, 6'h00, 0, 2, 0, cyc, mrq);
        check("lw_wait_cycles", cyc, 32'd7);
        check("lw_mem_req_cycles", mrq, 32'd3);

        // Halt raised during EX of ADDI: WB still completes, then HALT.
        exec(6'h08, 6'h00, 0, 0, 1, cyc, mrq);
        mem_ready = 1'b1;
        #1;
        check("halt_if_cycle", 32'(obs()), 32'(mk(0, 1'b0, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            check("halted_idle", 32'(obs()), 32'(mk(0, 1'b0, 1'b0, 1'b0, 1'b1)));
            @(negedge clk);
        end
        halt = 1'b0;
        #1;
        check("halt_release", 32'(obs()), 32'(mk(0, 1'b0, 1'b0, 1'b0, 1'b1)));
        @(negedge clk);
        exec(6'h08, 6'h00, 0, 0, 0, cyc, mrq);
        check("resume_cpi", cyc, 32'd4);

        // Asynchronous reset while LW waits in MEM.
        op_code = 6'h23;
        funct = 6'h00;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("mem_wait_state", 32'(obs()), 32'(mk(0, 1'b1, 1'b0, 1'b0, 1'b0)));
        check("retired_before_rst", retired, ret_model);
        #2;
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_strobes_drop", 32'(obs()), 32'd0);
        check("rst_retired_clear", retired, 32'd0);
        ret_model = '0;
        @(negedge clk);
        rst = 1'b1;
        exec(6'h08, 6'h00, 0, 0, 0, cyc, mrq);
        check("post_rst_cpi", cyc, 32'd4);

        // Randomized instructions and handshake delays.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) != 0) op = known[$urandom_range(0, known.size() - 1)];
            else op = 6'($urandom);
            fn = ($urandom_range(0, 4) == 0) ? 6'h08 : 6'($urandom);
            exec(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 0, cyc, mrq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multicycle control sequencer for the MIPS32 core. It steps each instruction through IF → ID → optional EX/MEM/WB and issues exactly one single-cycle commit strobe per executed stage. The stage footprint comes from the latched opcode/funct. Memory stages wait on a ready handshake. The block sits between the instruction register/decoder and the stage registers, and provides per-stage enables as clean, glitch-free synchronous signals.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `op_code`  in  `OP_WIDTH` (6)  opcode field of the current instruction register.
- `funct`  in  6  funct field; used only when `op_code` = `R_TYPE`.
- `mem_ready`  in  1  memory handshake; completes IF and MEM stages.
- `halt`  in  1  halt request; sampled only in state IF.
- `if_en`, `id_en`, `ex_en`, `mem_en`, `wb_en`  out  1 each  single-cycle stage commit strobes; at most one high per cycle.
- `mem_req`  out  1  high while in IF or MEM, waiting for `mem_ready`.
- `instr_done`  out  1  pulses on the commit cycle of an instruction's last stage.
- `illegal_op`  out  1  pulses on the ID commit when the opcode is unrecognised.
- `halted`  out  1  high while in HALT.
- `retired`  out  `CNT_W`  count of completed instructions.

## Operation
- FSM states: IF, ID, EX, MEM, WB, HALT.
- Reset values: state = IF, footprint = 0, `retired` = 0, all outputs 0.
- **IF**
  - If `halt`=1, go to HALT; no strobe, `mem_req`=0.
  - Otherwise `mem_req`=1. On `mem_ready`=1, pulse `if_en` and go to ID.
  - The state may wait any number of cycles.
- **ID**
  - Always one cycle. Pulse `id_en`.
  - Latch footprint {ex,mem,wb} from `op_code`/`funct`.
  - Go to the first set stage of the footprint, or to IF if the footprint is empty.
- **EX**, **WB**: always one cycle. Pulse the stage's strobe, then go to the next set footprint stage, or to IF.
- **MEM**: `mem_req`=1. On `mem_ready`, pulse `mem_en`, then go to WB if wb is set, else to IF.
- **Footprints** ({ex,mem,wb}):
  - R_TYPE (funct≠JR), ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, JAL: 101.
  - LB, LBU, LH, LHU, LW: 111.
  - SB, SH, SW: 110.
  - BEQ, BNE, BLEZ, BGTZ, BGEZ_BLTZ, J, R_TYPE with funct=JR: 100.
  - Any other opcode: 000. Pulse `illegal_op` together with `id_en`; the instruction retires as a NOP.
- `instr_done` is asserted with the strobe of the final stage. For footprint 000, it is asserted with `id_en`.
- `retired` increments by 1 on each `instr_done` and wraps modulo 2^`CNT_W`.
- **HALT**: `halted`=1, no strobes. When `halt`=0, go to IF. The fetch restarts on the next cycle.
- `mem_ready` is ignored outside IF and MEM.
- `halt` is ignored outside IF; an in-flight instruction always completes first.
- Reset asserted mid-instruction: immediately returns to IF, and all strobes drop asynchronously. No partial retire is counted.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from `op_code`/`funct` to any strobe.
  - Exception: strobes in IF/MEM are gated by `mem_ready` in the same cycle.
- Cycles per instruction with `mem_ready` held at 1:
  - ALU / LUI / JAL: 4.
  - Load: 5.
  - Store: 4.
  - Branch / J / JR: 3.
  - Illegal: 2.
- Each memory stage adds one cycle per cycle that `mem_ready` is low.
- The footprint is latched at the ID rising edge. `op_code` must be stable from the `if_en` commit through the ID cycle.

## Structure
- Add the following to `defines.v`:
  - opcode and funct constants (`R_TYPE`, `JR`, etc.);
  - state encodings;
  - footprint bit positions.
- Sub-module `footprint_decode`: purely combinational, {`op_code`, `funct`} → {ex, mem, wb, illegal}.
- The FSM, strobe decode and retire counter stay in `stage_sequencer`.

## Test plan
- Reset release, `mem_ready`=1, `op_code`=0x08 (ADDI) held → strobes if,id,ex,wb on cycles 0–3; `instr_done` on cycle 3; `retired`=1 after 4 cycles.
- LW (0x23) with `mem_ready` low for 2 cycles in MEM → strobe order if,id,ex,(wait,wait),mem,wb; 7 cycles total; `mem_req` high for exactly 3 cycles in MEM.
- SW (0x2B), BEQ (0x04), R_TYPE with funct=0x08 (JR) back-to-back → 4, 3 and 3 cycles; no `wb_en` for any of them.
- `op_code`=0x3F → `illegal_op` and `instr_done` together with `id_en`; next cycle back in IF; `retired` increments.
- `halt`=1 asserted during EX of an ADDI → WB completes, then HALT; `halted`=1 and no strobes for 10 cycles; `halt`=0 → `if_en` resumes.
- `rst`=0 asserted asynchronously mid-MEM of LW → strobes drop immediately, `retired` unchanged until reset then 0; after release, fetch restarts in IF. Preload `retired`=2^32−1 via repeated NOPs or force → the next retire wraps to 0.
